// File: rtl/la_capture_pkg.sv
// la_capture_pkg
//   Shared definitions for the logic-analyser capture engine:
//   - state_e     : capture FSM states
//   - trig_mode_t : trigger mode encoding (TRIG_LEVEL/RISE/CHANGE/NOW)
package la_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef logic [1:0] trig_mode_t;

    localparam trig_mode_t TRIG_LEVEL  = 2'd0;  // masked equality
    localparam trig_mode_t TRIG_RISE   = 2'd1;  // transition into masked equality
    localparam trig_mode_t TRIG_CHANGE = 2'd2;  // any change on masked bits
    localparam trig_mode_t TRIG_NOW    = 2'd3;  // first armed sample

endpackage

// File: rtl/la_capture_ram.sv
// la_capture_ram
//   Simple dual-port sample buffer: one write port, one registered read
//   port, no reset so it maps onto block RAM.
//   Ports:
//     clk    - clock
//     we     - write enable
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address
//     rdata  - mem[raddr], one cycle after raddr is presented
module la_capture_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// la_capture_core
//   Capture engine: pre-trigger fill, masked trigger compare (level, rise,
//   change, immediate), post-trigger fill, and readback of the circular
//   buffer.
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     run, abort                - start capture / return to IDLE
//     cqual                     - sample qualifier
//     data_in                   - probe data
//     trig_mask/value/mode      - trigger configuration (latched on run)
//     pre_count                 - samples kept before the trigger (latched)
//     armed, triggered, done    - registered status flags
//     trig_addr, start_addr     - trigger sample / oldest sample address
//     rd_addr, rd_data          - readback port, one-cycle latency
module la_capture_core
    import la_capture_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              abort,
    input  logic              cqual,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [1:0]        trig_mode,
    input  logic [ADDR_W-1:0] pre_count,
    output logic              armed,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    function automatic logic masked_eq(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic [DATA_W-1:0] mask);
        return ((a ^ b) & mask) == '0;
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] value_q, value_d;
    trig_mode_t        mode_q, mode_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_m_q, prev_m_d;
    logic              prev_valid_q, prev_valid_d;
    logic              armed_q, armed_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic              rd_en_q, rd_en_d;

    logic              start;
    logic              we;
    logic              cur_m;
    logic              hit_cond;
    logic              hit;
    logic [DATA_W-1:0] ram_rdata;

    // run is only honoured from IDLE/DONE, and abort always wins
    assign start = run && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign we    = cqual && !abort &&
                   (state_q == ST_FILL || state_q == ST_ARMED || state_q == ST_POST);

    // Trigger compare on the incoming sample against latched configuration
    always_comb begin
        cur_m = masked_eq(data_in, value_q, mask_q);
        case (mode_q)
            TRIG_LEVEL:  hit_cond = cur_m;
            TRIG_RISE:   hit_cond = cur_m && prev_valid_q && !prev_m_q;
            TRIG_CHANGE: hit_cond = prev_valid_q && !masked_eq(data_in, prev_q, mask_q);
            default:     hit_cond = 1'b1;
        endcase
        hit = we && (state_q == ST_ARMED) && hit_cond;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run) state_d = (pre_count == '0) ? ST_ARMED : ST_FILL;
                end
                ST_FILL: begin
                    if (we && (fill_q + ONE) == pre_q) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    // ~pre_q is DEPTH-1-pre_count: the post-trigger sample count
                    if (hit) state_d = (~pre_q == '0) ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (we && post_q == ONE) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered flag outputs
    always_comb begin
        mask_d       = mask_q;
        value_d      = value_q;
        mode_d       = mode_q;
        pre_d        = pre_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        post_d       = post_q;
        prev_d       = prev_q;
        prev_m_d     = prev_m_q;
        prev_valid_d = prev_valid_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        rd_en_d      = 1'b1;

        if (start) begin
            mask_d       = trig_mask;
            value_d      = trig_value;
            mode_d       = trig_mode;
            pre_d        = pre_count;
            wr_ptr_d     = '0;
            fill_d       = '0;
            prev_valid_d = 1'b0;
        end

        if (we) begin
            wr_ptr_d     = wr_ptr_q + ONE;
            prev_d       = data_in;
            prev_m_d     = cur_m;
            prev_valid_d = 1'b1;
            if (state_q == ST_FILL) fill_d = fill_q + ONE;
            if (state_q == ST_POST) post_d = post_q - ONE;
        end

        if (hit) begin
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - pre_q;
            post_d       = ~pre_q;
        end

        armed_d     = (state_d == ST_ARMED);
        triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
        done_d      = (state_d == ST_DONE);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            prev_valid_q <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            prev_valid_q <= prev_valid_d;
            rd_en_q      <= rd_en_d;
        end
    end

    // Data registers, always loaded on run before use
    always_ff @(posedge clk) begin
        mask_q   <= mask_d;
        value_q  <= value_d;
        mode_q   <= mode_d;
        pre_q    <= pre_d;
        wr_ptr_q <= wr_ptr_d;
        fill_q   <= fill_d;
        post_q   <= post_d;
        prev_q   <= prev_d;
        prev_m_q <= prev_m_d;
    end

    la_capture_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign armed      = armed_q;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;
    // RAM output is not reset; hold rd_data at zero until reset is released
    assign rd_data    = rd_en_q ? ram_rdata : '0;

endmodule

// File: tb/tb_la_capture_core.sv
module tb_la_capture_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       abort = 1'b0;
    logic       cqual = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] trig_mask = 8'hFF;
    logic [7:0] trig_value = 8'h00;
    logic [1:0] trig_mode = 2'd0;
    logic [3:0] pre_count = 4'd0;
    logic       armed, triggered, done;
    logic [3:0] trig_addr, start_addr;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;

    int tests_run = 0;
    int tests_failed = 0;

    la_capture_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort), .cqual(cqual),
        .data_in(data_in), .trig_mask(trig_mask), .trig_value(trig_value),
        .trig_mode(trig_mode), .pre_count(pre_count), .armed(armed),
        .triggered(triggered), .done(done), .trig_addr(trig_addr),
        .start_addr(start_addr), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] d);
        data_in = d;
        cqual = 1'b1;
        tick();
        cqual = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] pre, input logic [1:0] mode,
                             input logic [7:0] mask, input logic [7:0] value);
        pre_count = pre; trig_mode = mode; trig_mask = mask; trig_value = value;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests_run++; if ({armed, triggered, done} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {armed, triggered, done}); end
        tests_run++; if (trig_addr !== 4'd0) begin tests_failed++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
        tests_run++; if (start_addr !== 4'd0) begin tests_failed++; $display("FAIL reset_start_addr: got %0d want 0", start_addr); end
        tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        rst = 1'b0;
        tick();
    endtask

    // Level trigger at 0x2A, pre_count 4; gap=1 interleaves unqualified junk cycles
    task automatic test_level(input string tag, input bit gap);
        logic [7:0] exp;
        start_run(4'd4, 2'd0, 8'hFF, 8'h2A);
        tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL %s_fill_armed: got %b want 0", tag, armed); end
        for (int k = 0; k < 22; k++) begin
            sample(8'(8'h20 + k));
            if (k == 2) begin
                tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL %s_armed_early: got %b want 0", tag, armed); end
            end
            if (k == 3) begin
                tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL %s_armed: got %b want 1", tag, armed); end
            end
            if (k == 9) begin
                tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL %s_trig_early: got %b want 0", tag, triggered); end
            end
            if (k == 10) begin
                tests_run++; if ({armed, triggered} !== 2'b01) begin tests_failed++; $display("FAIL %s_trig_flags: got %b want 01", tag, {armed, triggered}); end
                tests_run++; if (trig_addr !== 4'd10) begin tests_failed++; $display("FAIL %s_trig_addr: got %0d want 10", tag, trig_addr); end
            end
            if (k == 20) begin
                tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL %s_done_early: got %b want 0", tag, done); end
            end
            if (k == 21) begin
                tests_run++; if ({done, triggered} !== 2'b11) begin tests_failed++; $display("FAIL %s_done: got %b want 11", tag, {done, triggered}); end
                tests_run++; if (start_addr !== 4'd6) begin tests_failed++; $display("FAIL %s_start_addr: got %0d want 6", tag, start_addr); end
            end
            if (gap) begin
                data_in = 8'hEE;
                tick();
            end
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            exp = 8'(8'h26 + ((a - 6) & 15));
            tests_run++; if (rd_data !== exp) begin tests_failed++; $display("FAIL %s_mem[%0d]: got %h want %h", tag, a, rd_data, exp); end
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL %s_done_hold: got %b want 1", tag, done); end
    endtask

    task automatic test_rise();
        start_run(4'd0, 2'd1, 8'hFF, 8'h55);
        tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL rise_armed: got %b want 1", armed); end
        sample(8'h55); sample(8'h55); sample(8'h55);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL rise_held: got %b want 0", triggered); end
        sample(8'h00);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL rise_low: got %b want 0", triggered); end
        sample(8'h55);
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL rise_trig: got %b want 1", triggered); end
        tests_run++; if (trig_addr !== 4'd4) begin tests_failed++; $display("FAIL rise_trig_addr: got %0d want 4", trig_addr); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_change();
        start_run(4'd2, 2'd2, 8'h01, 8'h00);
        sample(8'h10); sample(8'h12);
        tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL change_armed: got %b want 1", armed); end
        sample(8'h14); sample(8'h86); sample(8'hFE);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL change_upper_bits: got %b want 0", triggered); end
        sample(8'hFF);
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL change_trig: got %b want 1", triggered); end
        tests_run++; if (trig_addr !== 4'd5) begin tests_failed++; $display("FAIL change_trig_addr: got %0d want 5", trig_addr); end
        for (int k = 0; k < 13; k++) sample(8'(k));
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL change_done: got %b want 1", done); end
        tests_run++; if (start_addr !== 4'd3) begin tests_failed++; $display("FAIL change_start_addr: got %0d want 3", start_addr); end
    endtask

    task automatic test_immediate();
        start_run(4'd0, 2'd3, 8'h00, 8'h00);
        tests_run++; if ({armed, done} !== 2'b10) begin tests_failed++; $display("FAIL imm_armed: got %b want 10", {armed, done}); end
        sample(8'h80);
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL imm_trig: got %b want 1", triggered); end
        tests_run++; if (trig_addr !== 4'd0) begin tests_failed++; $display("FAIL imm_trig_addr: got %0d want 0", trig_addr); end
        for (int k = 1; k < 16; k++) begin
            sample(8'(8'h80 + k));
            if (k == 14) begin
                tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL imm_done_early: got %b want 0", done); end
            end
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL imm_done: got %b want 1", done); end
        tests_run++; if (start_addr !== 4'd0) begin tests_failed++; $display("FAIL imm_start_addr: got %0d want 0", start_addr); end
        rd_addr = 4'd15; tick();
        tests_run++; if (rd_data !== 8'h8F) begin tests_failed++; $display("FAIL imm_mem15: got %h want 8f", rd_data); end
    endtask

    task automatic test_abort_post();
        start_run(4'd0, 2'd3, 8'h00, 8'h00);
        sample(8'h11); sample(8'h12); sample(8'h13);
        abort = 1'b1; tick(); abort = 1'b0;
        tests_run++; if ({armed, triggered, done} !== 3'b000) begin tests_failed++; $display("FAIL abort_flags: got %b want 000", {armed, triggered, done}); end
        sample(8'h99);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got %b want 0", triggered); end
        start_run(4'd0, 2'd3, 8'h00, 8'h00);
        for (int k = 0; k < 16; k++) sample(8'(8'h40 + k));
        tests_run++; if ({done, trig_addr} !== {1'b1, 4'd0}) begin tests_failed++; $display("FAIL abort_rerun: got %b/%0d want 1/0", done, trig_addr); end
        rd_addr = 4'd3; tick();
        tests_run++; if (rd_data !== 8'h43) begin tests_failed++; $display("FAIL abort_rerun_mem3: got %h want 43", rd_data); end
    endtask

    task automatic test_run_abort_same();
        abort = 1'b1; tick(); abort = 1'b0;
        pre_count = 4'd0; trig_mode = 2'd3;
        run = 1'b1; abort = 1'b1; tick(); run = 1'b0; abort = 1'b0;
        tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL runabort_armed: got %b want 0", armed); end
        sample(8'h01);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL runabort_trig: got %b want 0", triggered); end
    endtask

    task automatic test_run_in_armed();
        start_run(4'd0, 2'd0, 8'hFF, 8'hAA);
        sample(8'h00);
        // retrigger attempt with new config and a sample that would match it
        pre_count = 4'd5; trig_value = 8'h01; run = 1'b1;
        sample(8'h01);
        run = 1'b0;
        tests_run++; if ({armed, triggered} !== 2'b10) begin tests_failed++; $display("FAIL runarmed_state: got %b want 10", {armed, triggered}); end
        sample(8'hAA);
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL runarmed_trig: got %b want 1", triggered); end
        tests_run++; if (trig_addr !== 4'd2) begin tests_failed++; $display("FAIL runarmed_trig_addr: got %0d want 2", trig_addr); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level("lvl", 1'b0);
        test_level("qual", 1'b1);
        test_rise();
        test_change();
        test_immediate();
        test_abort_post();
        test_run_abort_same();
        test_run_in_armed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
